// File: rtl/serial_word_comparator.sv
// Bit-serial MSB-first word comparator driving an external one-bit comparator stage.
// Define CMP_EARLY_EXIT_EN to finish as soon as the first differing bit decides the result.
module serial_word_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_agb,
  input  logic             cmp_eg,
  input  logic             cmp_alb,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             eg,
  output logic             alb
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [1:0] {D_UND, D_GT, D_LT} dec_e;

  state_e          state_q, state_d;
  dec_e            dec_q, dec_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            agb_q, agb_d, eg_q, eg_d, alb_q, alb_d;
  logic            finish;

  // Equality is implied by neither agb nor alb being set, so cmp_eg carries no extra information.
  logic unused_eg;
  assign unused_eg = cmp_eg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dec_q   <= D_UND;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      agb_q   <= 1'b0;
      eg_q    <= 1'b0;
      alb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      agb_q   <= agb_d;
      eg_q    <= eg_d;
      alb_q   <= alb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    agb_d   = agb_q;
    eg_d    = eg_q;
    alb_d   = alb_q;
    finish  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d    = a_in;
          sb_d    = b_in;
          dec_d   = D_UND;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (dec_q == D_UND) begin
          if (cmp_agb)      dec_d = D_GT;
          else if (cmp_alb) dec_d = D_LT;
        end
        cnt_d  = cnt_q + 1'b1;
        sa_d   = {sa_q[WIDTH-2:0], 1'b0};
        sb_d   = {sb_q[WIDTH-2:0], 1'b0};
        finish = (cnt_q == CW'(WIDTH - 1));
`ifdef CMP_EARLY_EXIT_EN
        if (dec_q == D_UND && dec_d != D_UND) finish = 1'b1;
`endif
        // Clearing the shift regs here keeps cmp_a/cmp_b low outside SHIFT.
        if (finish) begin
          state_d = S_DONE;
          sa_d    = '0;
          sb_d    = '0;
          cnt_d   = '0;
          agb_d   = (dec_d == D_GT);
          alb_d   = (dec_d == D_LT);
          eg_d    = (dec_d == D_UND);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmp_a = sa_q[WIDTH-1];
  assign cmp_b = sb_q[WIDTH-1];
  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign agb   = agb_q;
  assign eg    = eg_q;
  assign alb   = alb_q;

endmodule
